// File: rtl/led_rotator.sv
// Accepts a 5-bit pattern over a valid/ready handshake, then rotates it one
// bit per prescaler tick for ROT_STEPS steps before pulsing done.
module led_rotator #(
    parameter int PRESC_BITS = 22,
    parameter int ROT_STEPS  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] data,
    input  logic       data_valid,
    output logic       data_ready,
    input  logic       dir,
    output logic [4:0] leds,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam logic [3:0] LAST_STEP = 4'(ROT_STEPS);

    logic [1:0]            state_q, state_d;
    logic [4:0]            leds_q, leds_d;
    logic [PRESC_BITS-1:0] presc_q, presc_d;
    logic [3:0]            step_q, step_d;
    logic                  dir_q, dir_d;
    logic                  tick;

    assign tick = (presc_q == {PRESC_BITS{1'b1}});

    always_comb begin
        state_d = state_q;
        leds_d  = leds_q;
        presc_d = '0;
        step_d  = step_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (data_valid) begin
                    leds_d  = data;
                    dir_d   = dir;
                    step_d  = 4'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // The step-count test precedes the tick so no rotation can
                // sneak in once the last step has been taken.
                if (step_q == LAST_STEP) begin
                    state_d = FINISH;
                end else begin
                    presc_d = presc_q + 1'b1;
                    if (tick) begin
                        leds_d = dir_q ? {leds_q[0], leds_q[4:1]}
                                       : {leds_q[3:0], leds_q[4]};
                        step_d = step_q + 4'd1;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            leds_q  <= 5'b00000;
            presc_q <= '0;
            step_q  <= 4'd0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            leds_q  <= leds_d;
            presc_q <= presc_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
        end
    end

    assign data_ready = (state_q == IDLE);
    assign busy       = (state_q == RUN);
    assign done       = (state_q == FINISH);
    assign leds       = leds_q;

endmodule
